fetch_queue_unit: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 4 +
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/fetch_queue_unit.sv | 97 +++++++++
 tb/tb_fetch_queue_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide scalar types used across the pipelined MIPS core.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/fetch_pkg.sv
// Types and constants shared by the decoupled fetch front end.
package fetch_pkg;
    import cpu_types_pkg::word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    typedef enum logic {FETCH, HALTED} fetch_state_t;

    localparam word_t PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry queue of fetched {pc, instr} pairs; flush clears it in one edge.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_entry_t       din,
    output fetch_entry_t       head,
    output logic               valid,
    output logic [CNT_W-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    fetch_entry_t     mem [DEPTH];
    logic             pop_ok;

    assign valid  = (count != '0);
    assign pop_ok = pop && valid;
    assign head   = valid ? mem[rd_ptr] : '0;

    // Control: pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is data only and carries no reset; head is masked while empty.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/fetch_queue_unit.sv
// Decoupled instruction-fetch front end: sequential i-cache requests, redirect flush, sticky halt.
// Optional FETCH_STATS_EN adds saturating fetched_cnt / flushed_cnt counters.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0,
    parameter int          DEPTH   = 4,
    parameter int          CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    output logic             imemREN,
    output logic [31:0]      imemaddr,
    input  logic             ihit,
    input  logic [31:0]      imemload,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    input  logic             halt,
    input  logic             deq,
    output logic             valid,
    output logic [31:0]      instr,
    output logic [31:0]      instr_pc,
    output logic [CNT_W-1:0] count
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]      fetched_cnt,
    output logic [31:0]      flushed_cnt
`endif
);
    fetch_state_t state, state_nxt;
    logic [31:0]  fetch_pc;
    logic         redirect_eff;
    logic         push;
    fetch_entry_t head;

    assign redirect_eff = (state == FETCH) && redirect;
    assign imemREN      = !RST && (state == FETCH) && (count < CNT_W'(DEPTH)) && !redirect;
    assign imemaddr     = fetch_pc;
    assign push         = ihit && imemREN;
    assign instr        = head.instr;
    assign instr_pc     = head.pc;

    always_ff @(posedge CLK) begin
        if (RST)
            state <= FETCH;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == FETCH && halt)
            state_nxt = HALTED;
    end

    always_ff @(posedge CLK) begin
        if (RST)
            fetch_pc <= PC_INIT;
        else if (redirect_eff)
            fetch_pc <= {redirect_pc[31:2], 2'b00};
        else if (push)
            fetch_pc <= fetch_pc + PC_STEP;
    end

    fetch_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .pop   (deq),
        .flush (redirect_eff),
        .din   ('{pc: fetch_pc, instr: imemload}),
        .head  (head),
        .valid (valid),
        .count (count)
    );

`ifdef FETCH_STATS_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Any ihit arriving with an effective redirect is dropped and counted as flushed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fetched_cnt <= '0;
            flushed_cnt <= '0;
        end else begin
            if (push)
                fetched_cnt <= sat_add(fetched_cnt, 32'd1);
            if (redirect_eff)
                flushed_cnt <= sat_add(flushed_cnt, 32'(count) + 32'(ihit));
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: vector table plus multi-cycle halt/reset/stats sequences.
module tb_fetch_queue_unit;
    logic        CLK, RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt, deq;
    logic        valid;
    logic [31:0] instr, instr_pc;
    logic [2:0]  count;
`ifdef FETCH_STATS_EN
    logic [31:0] fetched_cnt, flushed_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fetch_queue_unit #(.PC_INIT(32'h0), .DEPTH(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .deq        (deq),
        .valid      (valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .count      (count)
`ifdef FETCH_STATS_EN
        ,
        .fetched_cnt(fetched_cnt),
        .flushed_cnt(flushed_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        hl;
        logic        dq;
        logic        ih;
        logic [31:0] ld;
        logic        e_ren;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_cnt;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t vt[22];

    function automatic logic [31:0] d(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0000;
    endfunction

    function automatic vec_t mk(input logic rd, input logic [31:0] rpc, input logic hl,
                                input logic dq, input logic ih, input logic [31:0] ld,
                                input logic e_ren, input logic [31:0] e_addr, input logic e_vld,
                                input logic [31:0] e_cnt, input logic [31:0] e_pc,
                                input logic [31:0] e_ins);
        vec_t v;
        v.rd = rd; v.rpc = rpc; v.hl = hl; v.dq = dq; v.ih = ih; v.ld = ld;
        v.e_ren = e_ren; v.e_addr = e_addr; v.e_vld = e_vld;
        v.e_cnt = e_cnt; v.e_pc = e_pc; v.e_ins = e_ins;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic idle();
        redirect = 1'b0; redirect_pc = '0; halt = 1'b0; deq = 1'b0; ihit = 1'b0; imemload = '0;
    endtask

    initial begin
        // Fill from reset (PC_INIT=0), refill under deq, redirect flush, wrap, then halt/drain.
        vt[0]  = mk(0, 0,            0, 0, 1, d(0),          1, 32'h0,        0, 0, 0,            0);
        vt[1]  = mk(0, 0,            0, 0, 1, d(4),          1, 32'h4,        1, 1, 0,            d(0));
        vt[2]  = mk(0, 0,            0, 0, 1, d(8),          1, 32'h8,        1, 2, 0,            d(0));
        vt[3]  = mk(0, 0,            0, 0, 1, d(12),         1, 32'hC,        1, 3, 0,            d(0));
        vt[4]  = mk(0, 0,            0, 0, 1, d(16),         0, 32'h10,       1, 4, 0,            d(0));
        vt[5]  = mk(0, 0,            0, 1, 1, d(16),         0, 32'h10,       1, 4, 0,            d(0));
        vt[6]  = mk(0, 0,            0, 1, 1, d(16),         1, 32'h10,       1, 3, 32'h4,        d(4));
        vt[7]  = mk(0, 0,            0, 1, 1, d(20),         1, 32'h14,       1, 3, 32'h8,        d(8));
        vt[8]  = mk(1, 32'h103,      0, 0, 1, d(24),         0, 32'h18,       1, 3, 32'hC,        d(12));
        vt[9]  = mk(0, 0,            0, 1, 0, 0,             1, 32'h100,      0, 0, 0,            0);
        vt[10] = mk(0, 0,            0, 0, 1, d(32'h100),    1, 32'h100,      0, 0, 0,            0);
        vt[11] = mk(0, 0,            0, 0, 0, 0,             1, 32'h104,      1, 1, 32'h100,      d(32'h100));
        vt[12] = mk(1, 32'hFFFFFFF8, 0, 1, 0, 0,             0, 32'h104,      1, 1, 32'h100,      d(32'h100));
        vt[13] = mk(0, 0,            0, 0, 1, d(32'hFFFFFFF8), 1, 32'hFFFFFFF8, 0, 0, 0,          0);
        vt[14] = mk(0, 0,            0, 0, 1, d(32'hFFFFFFFC), 1, 32'hFFFFFFFC, 1, 1, 32'hFFFFFFF8, d(32'hFFFFFFF8));
        vt[15] = mk(0, 0,            0, 0, 0, 0,             1, 32'h0,        1, 2, 32'hFFFFFFF8, d(32'hFFFFFFF8));
        vt[16] = mk(0, 0,            1, 0, 1, d(0),          1, 32'h0,        1, 2, 32'hFFFFFFF8, d(32'hFFFFFFF8));
        vt[17] = mk(0, 0,            0, 1, 1, d(4),          0, 32'h4,        1, 3, 32'hFFFFFFF8, d(32'hFFFFFFF8));
        vt[18] = mk(1, 32'h200,      0, 1, 0, 0,             0, 32'h4,        1, 2, 32'hFFFFFFFC, d(32'hFFFFFFFC));
        vt[19] = mk(0, 0,            0, 1, 0, 0,             0, 32'h4,        1, 1, 32'h0,        d(0));
        vt[20] = mk(0, 0,            0, 1, 0, 0,             0, 32'h4,        0, 0, 0,            0);
        vt[21] = mk(0, 0,            0, 0, 0, 0,             0, 32'h4,        0, 0, 0,            0);

        idle();
        RST = 1'b1;
        @(negedge CLK);
        #1 chk("rst.ren", 32'(imemREN), 0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst.count", 32'(count), 0);
        chk("rst.valid", 32'(valid), 0);
        chk("rst.instr", instr, 0);
        chk("rst.instr_pc", instr_pc, 0);
        chk("rst.addr", imemaddr, 32'h0);

        for (int i = 0; i < 22; i++) begin
            redirect = vt[i].rd; redirect_pc = vt[i].rpc; halt = vt[i].hl;
            deq = vt[i].dq; ihit = vt[i].ih; imemload = vt[i].ld;
            #1;
            chk($sformatf("row%0d.ren", i),   32'(imemREN), 32'(vt[i].e_ren));
            chk($sformatf("row%0d.addr", i),  imemaddr,     vt[i].e_addr);
            chk($sformatf("row%0d.valid", i), 32'(valid),   32'(vt[i].e_vld));
            chk($sformatf("row%0d.count", i), 32'(count),   vt[i].e_cnt);
            chk($sformatf("row%0d.pc", i),    instr_pc,     vt[i].e_pc);
            chk($sformatf("row%0d.instr", i), instr,        vt[i].e_ins);
            @(negedge CLK);
        end

        // Reset leaves HALTED; then reset in the middle of an outstanding request.
        idle();
        RST = 1'b1; ihit = 1'b1;
        #1 chk("rst2.ren", 32'(imemREN), 0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst2.count", 32'(count), 0);
        chk("rst2.ren_after", 32'(imemREN), 1);
        @(negedge CLK);
        @(negedge CLK);
        #1 chk("mid.count", 32'(count), 2);
        RST = 1'b1;
        #1 chk("mid.ren", 32'(imemREN), 0);
        @(negedge CLK);
        RST = 1'b0; ihit = 1'b0;
        #1;
        chk("mid.count_after", 32'(count), 0);
        chk("mid.valid_after", 32'(valid), 0);
        chk("mid.addr_after", imemaddr, 32'h0);

        // halt and redirect together: flush applies, then halted.
        ihit = 1'b1;
        @(negedge CLK);
        halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h43;
        #1 chk("hr.ren_same", 32'(imemREN), 0);
        @(negedge CLK);
        halt = 1'b0; redirect = 1'b0;
        #1;
        chk("hr.count", 32'(count), 0);
        chk("hr.valid", 32'(valid), 0);
        chk("hr.addr", imemaddr, 32'h40);
        chk("hr.ren", 32'(imemREN), 0);
        @(negedge CLK);
        redirect = 1'b1; redirect_pc = 32'h80;
        @(negedge CLK);
        redirect = 1'b0;
        #1 chk("hr.redir_ignored", imemaddr, 32'h40);

`ifdef FETCH_STATS_EN
        idle();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0; ihit = 1'b1;
        repeat (3) @(negedge CLK);
        deq = 1'b1;
        repeat (2) @(negedge CLK);
        ihit = 1'b0; deq = 1'b0;
        #1 chk("stats.count_pre", 32'(count), 3);
        redirect = 1'b1; redirect_pc = 32'h300;
        @(negedge CLK);
        redirect = 1'b0;
        #1;
        chk("stats.count", 32'(count), 0);
        chk("stats.fetched", fetched_cnt, 32'd5);
        chk("stats.flushed", flushed_cnt, 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
